inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Front-end fetch stage directly upstream of the L1 instruction cache.
- Owns the PC and issues one-at-a-time read requests to the cache (inst_rreq/inst_addr); consumes inst_valid/inst_out.
- Buffers fetched {pc, inst} pairs in a small FIFO feeding decode over a valid/ready handshake.
- Handles branch/exception redirects, including discarding a response that is already in flight.

Parameters:
- RESET_PC, 32'h1C00_0000, first fetch address after reset.
- IBUF_DEPTH, 4, instruction buffer entries (power of 2, >= 2).

Ports:
- cpu_clk  input  1  clock
- cpu_rst  input  1  reset
- redirect_valid  input  1  flush buffer, restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address (word aligned)
- inst_rreq  output  1  cache request, one-cycle pulse
- inst_addr  output  32  request address, held stable until matching inst_valid
- inst_valid  input  1  cache response strobe, one cycle
- inst_out  input  32  cache instruction word
- id_valid  output  1  buffer head valid
- id_ready  input  1  decode accepts head
- id_pc  output  32  head PC
- id_inst  output  32  head instruction

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=REQ, pc=RESET_PC, inst_rreq=0, inst_addr=RESET_PC, buffer empty, id_valid=0, id_pc=0, id_inst=0, drop=0.
- Reset asserted mid-request: the cache is reset on the same reset tree, so no response is expected afterwards.
- Credit rule: a request is allowed only when count + outstanding < IBUF_DEPTH. A push can therefore never overflow the buffer.
- State machine:
  - REQ: if credit available and no redirect this cycle, then inst_rreq=1, inst_addr<=pc (registered), go to WAIT. Otherwise stay in REQ.
  - WAIT: inst_rreq=0; inst_addr held. On inst_valid:
    - if drop=0, push {inst_addr, inst_out} and set pc<=inst_addr+4;
    - if drop=1, discard the response and clear drop.
    - In both cases go to GAP.
  - GAP: one idle cycle, because the cache samples rreq only while it is idle. Then go to REQ.
- Latency: on a cache hit, rreq at cycle T, inst_valid at T+1, entry visible on id_valid at T+2, next rreq at T+3. Peak throughput is one instruction per 3 cycles.
- Redirect:
  - Buffer is cleared in the same cycle.
  - pc<=redirect_pc.
  - If in WAIT and inst_valid has not yet arrived, set drop=1. inst_addr must NOT change until the dropped response arrives, because the cache refills using inst_addr.
  - Redirect coincident with inst_valid in WAIT: discard that response; the next request goes to redirect_pc.
  - Redirect coincident with an id_ready pop: flush wins.
  - Redirect in REQ: suppresses rreq that cycle; the request to redirect_pc issues next cycle.
- Buffer: circular FIFO with wrapping read/write pointers and a count register.
  - id_valid = (count != 0).
  - id_pc/id_inst are driven from the head entry.
  - Pop when id_valid && id_ready.
  - Push and pop in the same cycle are both allowed; count is unchanged.
- Outputs stay stable while id_valid=1 and id_ready=0.
- PC arithmetic: 32-bit, wraps modulo 2^32. Low 2 bits of redirect_pc are forced to 0.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (count of accepted, non-dropped responses) and perf_wait_cyc[31:0] (cycles spent in WAIT).
  - Both are cleared by reset and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, cache always hits, id_ready=1 -> rreq addresses 0x1C000000, 0x1C000004, 0x1C000008, one every 3 cycles; id_pc matches and id_inst equals the cache word.
- id_ready=0 held -> exactly 4 requests issue, then rreq stays 0. After id_ready=1 the heads pop in order 0x1C000000..0x1C00000C and fetching resumes at 0x1C000010.
- Cache miss (inst_valid after 20 cycles) and redirect_pc=0x1C000100 at WAIT cycle 5 -> inst_addr holds 0x1C000000 until inst_valid; that response is not enqueued; next rreq addresses 0x1C000100.
- Redirect in the same cycle as inst_valid and id_ready pop with 2 entries buffered -> buffer empty next cycle, response dropped, next request to redirect_pc.
- redirect_pc=0xFFFFFFFC -> following fetch address is 0x00000000.
- With IFETCH_PERF_CNT_EN: after 10 hits and 1 dropped miss -> perf_fetch_cnt=10 and perf_wait_cyc equals the measured WAIT cycles.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: redirect input, L1 I-cache request/response, decode handshake.
// master = fetch unit side, slave = surrounding pipeline/cache side.
interface inst_fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_rreq;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    modport master (
        input  redirect_valid, redirect_pc, inst_valid, inst_out, id_ready,
        output inst_rreq, inst_addr, id_valid, id_pc, id_inst
    );

    modport slave (
        output redirect_valid, redirect_pc, inst_valid, inst_out, id_ready,
        input  inst_rreq, inst_addr, id_valid, id_pc, id_inst
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time I-cache reads,
// buffers {pc, inst} pairs for decode and handles redirects (incl. in-flight drop).
// Optional: define IFETCH_PERF_CNT_EN to add saturating perf counters
// perf_fetch_cnt (accepted responses) and perf_wait_cyc (cycles spent waiting on the cache).
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h1C00_0000,
    parameter int unsigned IBUF_DEPTH = 4
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_wait_cyc,
`endif
    inst_fetch_unit_if.master   bus
);

    localparam int unsigned PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;

    state_t             state_q,     state_d;
    logic [31:0]        pc_q,        pc_d;
    logic               inst_rreq_q, inst_rreq_d;
    logic [31:0]        inst_addr_q, inst_addr_d;
    logic               drop_q,      drop_d;
    logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    ibuf_entry_t        ibuf_q [IBUF_DEPTH];
    ibuf_entry_t        ibuf_d [IBUF_DEPTH];
    logic               id_valid_q,  id_valid_d;
    logic [31:0]        id_pc_q,     id_pc_d;
    logic [31:0]        id_inst_q,   id_inst_d;

    logic               push_c;
    logic               pop_c;
    logic               credit_c;
    logic               outstanding_c;
    logic [31:0]        redirect_pc_c;

    // Next-state: fetch FSM, PC, redirect/drop tracking and instruction buffer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_rreq_d = 1'b0;
        inst_addr_d = inst_addr_q;
        drop_d      = drop_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ibuf_d      = ibuf_q;
        push_c      = 1'b0;
        pop_c       = id_valid_q && bus.id_ready;

        redirect_pc_c = bus.redirect_pc & ~32'h0000_0003;
        outstanding_c = (state_q == S_WAIT);
        credit_c      = (CNT_W'(count_q) + CNT_W'(outstanding_c)) < CNT_W'(IBUF_DEPTH);

        case (state_q)
            // The gap cycle already evaluates the issue rule so the registered
            // rreq lands right after the single idle cycle (3-cycle cadence).
            S_REQ, S_GAP: begin
                if (credit_c && !bus.redirect_valid) begin
                    inst_rreq_d = 1'b1;
                    inst_addr_d = pc_q;
                    state_d     = S_WAIT;
                end else begin
                    state_d     = S_REQ;
                end
            end
            S_WAIT: begin
                if (bus.inst_valid) begin
                    if (!drop_q && !bus.redirect_valid) begin
                        push_c = 1'b1;
                        pc_d   = inst_addr_q + 32'd4;
                    end
                    drop_d  = 1'b0;
                    state_d = S_GAP;
                end else if (bus.redirect_valid) begin
                    // Cache still refills from inst_addr, so keep it and discard the reply.
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (bus.redirect_valid) begin
            pc_d     = redirect_pc_c;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                ibuf_d[wr_ptr_q] = '{pc: inst_addr_q, inst: bus.inst_out};
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end

        id_valid_d = (count_d != '0);
        id_pc_d    = ibuf_d[rd_ptr_d].pc;
        id_inst_d  = ibuf_d[rd_ptr_d].inst;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            inst_rreq_q <= 1'b0;
            inst_addr_q <= RESET_PC;
            drop_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int unsigned i = 0; i < IBUF_DEPTH; i++) begin
                ibuf_q[i] <= '0;
            end
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            id_inst_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_rreq_q <= inst_rreq_d;
            inst_addr_q <= inst_addr_d;
            drop_q      <= drop_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ibuf_q      <= ibuf_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
        end
    end

    assign bus.inst_rreq = inst_rreq_q;
    assign bus.inst_addr = inst_addr_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_inst   = id_inst_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_wait_cyc_q,  perf_wait_cyc_d;

    // Saturating counters: accepted responses and cycles waiting on the cache.
    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q;
        perf_wait_cyc_d  = perf_wait_cyc_q;
        if (push_c && (perf_fetch_cnt_q != 32'hFFFF_FFFF)) begin
            perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
        end
        if (outstanding_c && (perf_wait_cyc_q != 32'hFFFF_FFFF)) begin
            perf_wait_cyc_d = perf_wait_cyc_q + 32'd1;
        end
    end

    // Perf counter registers.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            perf_fetch_cnt_q <= '0;
            perf_wait_cyc_q  <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_wait_cyc_q  <= perf_wait_cyc_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_wait_cyc  = perf_wait_cyc_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a small latency-programmable I-cache model.
module tb_inst_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cache_lat = 1;
    int   remaining = 0;
    logic [31:0] req_addr_pend = '0;
    logic [31:0] req_log [$];
    int          req_cyc [$];

    inst_fetch_unit_if bus();

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cyc;
`endif

    inst_fetch_unit #(
        .RESET_PC   (RST_PC),
        .IBUF_DEPTH (4)
    ) dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst        (cpu_rst),
`ifdef IFETCH_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_wait_cyc  (perf_wait_cyc),
`endif
        .bus            (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) cyc <= cyc + 1;

    function automatic logic [31:0] cache_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Cache model: latches a request, answers cache_lat cycles later with a one-cycle strobe.
    initial begin
        bus.inst_valid = 1'b0;
        bus.inst_out   = '0;
        forever begin
            @(posedge cpu_clk);
            #1;
            bus.inst_valid = 1'b0;
            if (cpu_rst) begin
                remaining = 0;
            end else begin
                if (remaining > 0) begin
                    remaining--;
                    if (remaining == 0) begin
                        bus.inst_valid = 1'b1;
                        bus.inst_out   = cache_word(req_addr_pend);
                    end
                end
                if (bus.inst_rreq) begin
                    req_addr_pend = bus.inst_addr;
                    remaining     = cache_lat;
                    req_log.push_back(bus.inst_addr);
                    req_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge cpu_clk);
        #2;
    endtask

    task automatic do_reset();
        cpu_rst            = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        cache_lat          = 1;
        repeat (3) step();
        cpu_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %0b want 0", bus.id_valid); end
        n_checks++; if (bus.inst_rreq !== 1'b0) begin n_fail++; $display("FAIL reset_rreq: got %0b want 0", bus.inst_rreq); end
        n_checks++; if (bus.inst_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", bus.inst_addr, RST_PC); end
        n_checks++; if (bus.id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", bus.id_pc); end
        n_checks++; if (bus.id_inst !== 32'h0) begin n_fail++; $display("FAIL reset_id_inst: got %h want 0", bus.id_inst); end
    endtask

    task automatic test_hits();
        int base;
        int first_valid;
        logic [31:0] pops [$];
        logic [31:0] insts [$];
        do_reset();
        bus.id_ready = 1'b1;
        base = req_log.size();
        first_valid = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (first_valid < 0 && bus.id_valid) first_valid = cyc;
            if (bus.id_valid && bus.id_ready) begin
                pops.push_back(bus.id_pc);
                insts.push_back(bus.id_inst);
            end
        end
        n_checks++;
        if (req_log.size() < base + 3 || pops.size() < 3) begin
            n_fail++; $display("FAIL hits_count: reqs %0d pops %0d want >=3 each", req_log.size() - base, pops.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (req_log[base+i] !== RST_PC + 32'(4*i)) begin n_fail++; $display("FAIL hits_addr%0d: got %h want %h", i, req_log[base+i], RST_PC + 32'(4*i)); end
                n_checks++; if (pops[i] !== RST_PC + 32'(4*i)) begin n_fail++; $display("FAIL hits_pc%0d: got %h want %h", i, pops[i], RST_PC + 32'(4*i)); end
                n_checks++; if (insts[i] !== cache_word(RST_PC + 32'(4*i))) begin n_fail++; $display("FAIL hits_inst%0d: got %h want %h", i, insts[i], cache_word(RST_PC + 32'(4*i))); end
            end
            for (int i = 1; i < 3; i++) begin
                n_checks++; if (req_cyc[base+i] - req_cyc[base+i-1] != 3) begin n_fail++; $display("FAIL hits_period%0d: got %0d want 3", i, req_cyc[base+i] - req_cyc[base+i-1]); end
            end
            n_checks++; if (first_valid != req_cyc[base] + 2) begin n_fail++; $display("FAIL hits_latency: got %0d want %0d", first_valid - req_cyc[base], 2); end
        end
    endtask

    task automatic test_backpressure();
        int base;
        logic [31:0] pops [$];
        do_reset();
        base = req_log.size();
        repeat (30) step();
        n_checks++; if (req_log.size() - base != 4) begin n_fail++; $display("FAIL bp_req_count: got %0d want 4", req_log.size() - base); end
        n_checks++; if (bus.inst_rreq !== 1'b0) begin n_fail++; $display("FAIL bp_rreq_idle: got %0b want 0", bus.inst_rreq); end
        n_checks++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL bp_id_valid: got %0b want 1", bus.id_valid); end
        n_checks++; if (bus.id_pc !== RST_PC || bus.id_inst !== cache_word(RST_PC)) begin n_fail++; $display("FAIL bp_head: got %h/%h want %h/%h", bus.id_pc, bus.id_inst, RST_PC, cache_word(RST_PC)); end
        bus.id_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (bus.id_valid && bus.id_ready) pops.push_back(bus.id_pc);
            step();
        end
        n_checks++;
        if (pops.size() < 4 || req_log.size() < base + 5) begin
            n_fail++; $display("FAIL bp_resume: pops %0d reqs %0d want >=4 and >=5", pops.size(), req_log.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (pops[i] !== RST_PC + 32'(4*i)) begin n_fail++; $display("FAIL bp_pop%0d: got %h want %h", i, pops[i], RST_PC + 32'(4*i)); end
            end
            n_checks++; if (req_log[base+4] !== 32'h1C00_0010) begin n_fail++; $display("FAIL bp_next_addr: got %h want 1c000010", req_log[base+4]); end
        end
        bus.id_ready = 1'b0;
    endtask

    task automatic test_miss_redirect();
        int base;
        bit ok;
        bit addr_ok;
        bit early_valid;
        do_reset();
        bus.id_ready = 1'b1;
        cache_lat = 20;
        base = req_log.size();
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (req_log.size() > base) begin ok = 1; break; end
            step();
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL miss_first_req: got none want 1"); return; end
        repeat (4) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1C00_0100;
        cache_lat          = 1;
        step();
        bus.redirect_valid = 1'b0;
        addr_ok = 1; early_valid = 0; ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (req_log.size() > base + 1) begin ok = 1; break; end
            if (bus.inst_addr !== RST_PC) addr_ok = 0;
            if (bus.id_valid) early_valid = 1;
            step();
        end
        n_checks++; if (!addr_ok) begin n_fail++; $display("FAIL miss_addr_hold: got changed want %h held", RST_PC); end
        n_checks++; if (early_valid) begin n_fail++; $display("FAIL miss_dropped_enq: got id_valid=1 want 0"); end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL miss_next_req: got none want request"); return; end
        n_checks++; if (req_log[base+1] !== 32'h1C00_0100) begin n_fail++; $display("FAIL miss_next_addr: got %h want 1c000100", req_log[base+1]); end
        n_checks++; if (req_cyc[base+1] - req_cyc[base] != 22) begin n_fail++; $display("FAIL miss_gap: got %0d want 22", req_cyc[base+1] - req_cyc[base]); end
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.id_valid) begin ok = 1; break; end
            step();
        end
        n_checks++;
        if (!ok || bus.id_pc !== 32'h1C00_0100 || bus.id_inst !== cache_word(32'h1C00_0100)) begin
            n_fail++; $display("FAIL miss_head: got %0b %h/%h want 1 1c000100/%h", bus.id_valid, bus.id_pc, bus.id_inst, cache_word(32'h1C00_0100));
        end
        bus.id_ready = 1'b0;
    endtask

    task automatic test_redirect_collision();
        int base;
        bit ok;
        do_reset();
        base = req_log.size();
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (req_log.size() >= base + 3) begin ok = 1; break; end
            step();
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL coll_setup: got %0d reqs want 3", req_log.size() - base); return; end
        n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== RST_PC) begin n_fail++; $display("FAIL coll_pre_head: got %0b %h want 1 %h", bus.id_valid, bus.id_pc, RST_PC); end
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1C00_0202;
        bus.id_ready       = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b0;
        n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL coll_flush: got id_valid=%0b want 0", bus.id_valid); end
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (req_log.size() > base + 3 && bus.id_valid) begin ok = 1; break; end
            step();
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL coll_restart: got no request/entry want both"); return; end
        n_checks++; if (req_log[base+3] !== 32'h1C00_0200) begin n_fail++; $display("FAIL coll_next_addr: got %h want 1c000200", req_log[base+3]); end
        n_checks++; if (bus.id_pc !== 32'h1C00_0200) begin n_fail++; $display("FAIL coll_head: got %h want 1c000200", bus.id_pc); end
    endtask

    task automatic test_wrap();
        int base;
        bit ok;
        logic [31:0] pops [$];
        do_reset();
        bus.id_ready = 1'b1;
        base = req_log.size();
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            if (req_log.size() > base) begin ok = 1; break; end
            step();
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wrap_first_req: got none want 1"); return; end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.id_valid && bus.id_ready) pops.push_back(bus.id_pc);
            if (req_log.size() >= base + 3 && pops.size() >= 2) begin ok = 1; break; end
            step();
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wrap_progress: reqs %0d pops %0d want 3 and 2", req_log.size() - base, pops.size()); return; end
        n_checks++; if (req_log[base+1] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffffc", req_log[base+1]); end
        n_checks++; if (req_log[base+2] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_addr1: got %h want 00000000", req_log[base+2]); end
        n_checks++; if (pops[0] !== 32'hFFFF_FFFC || pops[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_pops: got %h,%h want fffffffc,00000000", pops[0], pops[1]); end
        bus.id_ready = 1'b0;
    endtask

`ifdef IFETCH_PERF_CNT_EN
    task automatic test_perf();
        int  exp_wait;
        int  exp_fetch;
        int  t_req;
        bit  in_wait;
        bit  drop_pend;
        bit  redirected;
        bit  done;
        do_reset();
        bus.id_ready = 1'b1;
        cache_lat = 20;
        exp_wait = 0; exp_fetch = 0; t_req = -1;
        in_wait = 0; drop_pend = 0; redirected = 0; done = 0;
        for (int k = 0; k < 200; k++) begin
            if (exp_fetch == 10) begin
                n_checks++; if (perf_fetch_cnt !== 32'd10) begin n_fail++; $display("FAIL perf_fetch: got %0d want 10", perf_fetch_cnt); end
                n_checks++; if (perf_wait_cyc !== 32'(exp_wait)) begin n_fail++; $display("FAIL perf_wait: got %0d want %0d", perf_wait_cyc, exp_wait); end
                done = 1;
                break;
            end
            bus.redirect_valid = 1'b0;
            if (bus.inst_rreq && t_req < 0) t_req = cyc;
            if (!redirected && t_req >= 0 && cyc == t_req + 2) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'h1C00_0400;
                cache_lat          = 1;
                redirected         = 1;
                drop_pend          = 1;
            end
            if (bus.inst_rreq || in_wait) exp_wait++;
            if (bus.inst_valid) begin
                in_wait = 0;
                if (drop_pend) drop_pend = 0;
                else exp_fetch++;
            end else if (bus.inst_rreq) begin
                in_wait = 1;
            end
            step();
        end
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL perf_timeout: got %0d fetches want 10", exp_fetch); end
        bus.id_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_hits();
        test_backpressure();
        test_miss_redirect();
        test_redirect_collision();
        test_wrap();
`ifdef IFETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
